// File: rtl/qtz_im_fetch_ctrl.sv
// Quantizes one beat of features into item-memory level addresses, fetches the level HVs
// and presents them downstream. Optional build macro: QTZ_ROUND_EN (round-to-nearest, saturating).
module qtz_im_fetch_ctrl #(
  parameter int HV_DIM          = 1024,
  parameter int FEATURES_PER_CC = 59,
  parameter int FEAT_WIDTH      = 8,
  parameter int LVL_W           = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                feat_valid,
  output logic                                feat_ready,
  input  logic [FEATURES_PER_CC*FEAT_WIDTH-1:0] feat_data,
  input  logic                                feat_last,
  output logic                                im_rd_en,
  output logic [FEATURES_PER_CC*LVL_W-1:0]    im_rd_addr,
  input  logic [FEATURES_PER_CC*HV_DIM-1:0]   im_rd_data,
  input  logic                                cons_busy,
  output logic [FEATURES_PER_CC*HV_DIM-1:0]   im_fetch_outputs,
  output logic                                qtz_out_reg_en,
  output logic                                mapping_hv_segment,
  output logic                                sample_done
);

  localparam int SH = FEAT_WIDTH - LVL_W;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PRESENT} state_t;

  state_t                              state_reg;
  logic [FEATURES_PER_CC*LVL_W-1:0]    lvl_next;
  logic [FEATURES_PER_CC*LVL_W-1:0]    addr_reg;
  logic [FEATURES_PER_CC*HV_DIM-1:0]   out_reg;
  logic                                rd_en_reg;
  logic                                last_reg;
  logic                                seg_reg;
  logic                                deliver;
  logic                                unused_feat_bits;

  // Truncation ignores the feature LSBs; fold them somewhere harmless.
  assign unused_feat_bits = ^feat_data;

  genvar gi;
  generate
    for (gi = 0; gi < FEATURES_PER_CC; gi++) begin : g_lvl
`ifdef QTZ_ROUND_EN
      if (LVL_W == FEAT_WIDTH) begin : g_pass
        assign lvl_next[gi*LVL_W +: LVL_W] = feat_data[gi*FEAT_WIDTH +: FEAT_WIDTH];
      end else begin : g_round
        localparam logic [FEAT_WIDTH:0] HALF = (FEAT_WIDTH+1)'(1) << ((SH > 0) ? SH - 1 : 0);
        localparam logic [FEAT_WIDTH:0] LMAX = (FEAT_WIDTH+1)'((1 << LVL_W) - 1);
        logic [FEAT_WIDTH:0] sum;
        logic [FEAT_WIDTH:0] shifted;
        // One extra bit so values near full scale round up instead of wrapping.
        assign sum     = {1'b0, feat_data[gi*FEAT_WIDTH +: FEAT_WIDTH]} + HALF;
        assign shifted = sum >> SH;
        assign lvl_next[gi*LVL_W +: LVL_W] = (shifted > LMAX) ? {LVL_W{1'b1}} : shifted[LVL_W-1:0];
      end
`else
      assign lvl_next[gi*LVL_W +: LVL_W] = feat_data[gi*FEAT_WIDTH + SH +: LVL_W];
`endif
    end
  endgenerate

  // Handshake and strobe are decoded from the state register so they react to rst and
  // cons_busy in the same cycle; everything else is a flop.
  assign feat_ready = (state_reg == IDLE) && !rst;
  assign deliver    = (state_reg == PRESENT) && !cons_busy && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      rd_en_reg <= 1'b0;
      addr_reg  <= '0;
      out_reg   <= '0;
      last_reg  <= 1'b0;
      seg_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (feat_valid) begin
            addr_reg  <= lvl_next;
            last_reg  <= feat_last;
            rd_en_reg <= 1'b1;
            state_reg <= FETCH;
          end
        end
        FETCH: begin
          rd_en_reg <= 1'b0;
          state_reg <= WAIT;
        end
        WAIT: begin
          out_reg   <= im_rd_data;
          state_reg <= PRESENT;
        end
        PRESENT: begin
          if (!cons_busy) begin
            seg_reg   <= last_reg ? 1'b0 : ~seg_reg;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign im_rd_en           = rd_en_reg;
  assign im_rd_addr         = addr_reg;
  assign im_fetch_outputs   = out_reg;
  assign qtz_out_reg_en     = deliver;
  assign mapping_hv_segment = seg_reg;
  assign sample_done        = deliver && last_reg;

endmodule

// File: tb/tb_qtz_im_fetch_ctrl.sv
// Scoreboard bench for qtz_im_fetch_ctrl with a small configuration and a behavioural item memory.
module tb_qtz_im_fetch_ctrl;

  localparam int HV  = 16;
  localparam int NF  = 3;
  localparam int FW  = 8;
  localparam int LW  = 4;
  localparam int DW  = NF * HV;
  localparam int AW  = NF * LW;
  localparam int FDW = NF * FW;

  logic           clk = 1'b0;
  logic           rst;
  logic           feat_valid;
  logic           feat_ready;
  logic [FDW-1:0] feat_data;
  logic           feat_last;
  logic           im_rd_en;
  logic [AW-1:0]  im_rd_addr;
  logic [DW-1:0]  im_rd_data = '0;
  logic           cons_busy;
  logic [DW-1:0]  im_fetch_outputs;
  logic           qtz_out_reg_en;
  logic           mapping_hv_segment;
  logic           sample_done;

  qtz_im_fetch_ctrl #(.HV_DIM(HV), .FEATURES_PER_CC(NF), .FEAT_WIDTH(FW), .LVL_W(LW)) dut (
    .clk(clk), .rst(rst), .feat_valid(feat_valid), .feat_ready(feat_ready),
    .feat_data(feat_data), .feat_last(feat_last), .im_rd_en(im_rd_en),
    .im_rd_addr(im_rd_addr), .im_rd_data(im_rd_data), .cons_busy(cons_busy),
    .im_fetch_outputs(im_fetch_outputs), .qtz_out_reg_en(qtz_out_reg_en),
    .mapping_hv_segment(mapping_hv_segment), .sample_done(sample_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] hv;
    logic          seg;
    logic          last;
    int            acc;
    int            lat;
  } exp_t;

  exp_t fq[$];
  exp_t oq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   next_lat = 3;
  bit   stream_on = 0;
  bit   have_prev = 0;
  int   prev_acc = 0;
  logic exp_seg = 1'b0;
  logic prev_rst = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [HV-1:0] memv(input int i, input logic [LW-1:0] l);
    int v;
    v = i * 499 + int'(l) * 945 + 1445;
    return v[HV-1:0];
  endfunction

  function automatic logic [LW-1:0] qlev(input logic [FW-1:0] f);
    int s;
`ifdef QTZ_ROUND_EN
    s = (int'(f) + (1 << (FW - LW - 1))) >> (FW - LW);
    if (s > (1 << LW) - 1) s = (1 << LW) - 1;
`else
    s = int'(f) >> (FW - LW);
`endif
    return s[LW-1:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Item memory: data is valid only in the cycle after a read strobe, garbage otherwise.
  always @(posedge clk) begin
    logic [DW-1:0] d;
    d = DW'({$urandom(), $urandom()});
    if (im_rd_en)
      for (int i = 0; i < NF; i++) d[i*HV +: HV] = memv(i, im_rd_addr[i*LW +: LW]);
    im_rd_data <= d;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_ready", 64'(feat_ready), 64'(0));
      chk("rst_strobe", 64'(qtz_out_reg_en), 64'(0));
      fq.delete();
      oq.delete();
      exp_seg = 1'b0;
    end else begin
      if (prev_rst) begin
        chk("post_rst_ready", 64'(feat_ready), 64'(1));
        chk("post_rst_rd_en", 64'(im_rd_en), 64'(0));
        chk("post_rst_addr", 64'(im_rd_addr), 64'(0));
        chk("post_rst_out", 64'(im_fetch_outputs), 64'(0));
        chk("post_rst_seg", 64'(mapping_hv_segment), 64'(0));
        chk("post_rst_done", 64'(sample_done), 64'(0));
      end
      if (feat_valid && feat_ready) begin
        for (int i = 0; i < NF; i++) begin
          e.addr[i*LW +: LW] = qlev(feat_data[i*FW +: FW]);
          e.hv[i*HV +: HV]   = memv(i, e.addr[i*LW +: LW]);
        end
        e.seg  = exp_seg;
        e.last = feat_last;
        e.acc  = cyc;
        e.lat  = next_lat;
        exp_seg = feat_last ? 1'b0 : ~exp_seg;
        fq.push_back(e);
        oq.push_back(e);
        if (stream_on) begin
          if (have_prev) chk("accept_gap", 64'(cyc - prev_acc), 64'(4));
          have_prev = 1;
          prev_acc  = cyc;
        end
      end
      if (im_rd_en) begin
        if (fq.size() == 0) chk("spurious_rd", 64'(im_rd_en), 64'(0));
        else begin
          e = fq.pop_front();
          chk("rd_addr", 64'(im_rd_addr), 64'(e.addr));
          chk("rd_lat", 64'(cyc - e.acc), 64'(1));
        end
      end
      if (cons_busy && oq.size() != 0 && cyc >= oq[0].acc + 3) begin
        chk("busy_out", 64'(im_fetch_outputs), 64'(oq[0].hv));
        chk("busy_seg", 64'(mapping_hv_segment), 64'(oq[0].seg));
        chk("busy_ready", 64'(feat_ready), 64'(0));
        chk("busy_strobe", 64'(qtz_out_reg_en), 64'(0));
      end
      if (qtz_out_reg_en) begin
        if (oq.size() == 0) chk("spurious_strobe", 64'(qtz_out_reg_en), 64'(0));
        else begin
          e = oq.pop_front();
          $display("beat acc=%0d out=%0h seg=%0d done=%0d", e.acc, im_fetch_outputs,
                   mapping_hv_segment, sample_done);
          chk("out_hv", 64'(im_fetch_outputs), 64'(e.hv));
          chk("out_seg", 64'(mapping_hv_segment), 64'(e.seg));
          chk("out_done", 64'(sample_done), 64'(e.last));
          chk("out_lat", 64'(cyc - e.acc), 64'(e.lat));
          chk("addr_hold", 64'(im_rd_addr), 64'(e.addr));
        end
      end else begin
        chk("done_no_strobe", 64'(sample_done), 64'(0));
      end
      if (oq.size() != 0 && cyc > oq[0].acc + oq[0].lat) begin
        chk("strobe_timeout", 64'(qtz_out_reg_en), 64'(1));
        void'(oq.pop_front());
      end
    end
    prev_rst = rst;
  end

  task automatic send(input logic [FDW-1:0] d, input logic last, input bit keep_valid);
    bit got;
    got = 0;
    feat_valid = 1'b1;
    feat_data  = d;
    feat_last  = last;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (feat_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("ready_timeout", 64'(feat_ready), 64'(1));
    @(posedge clk);
    #1;
    if (!keep_valid) feat_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    feat_valid = 1'b0;
    feat_data = '0;
    feat_last = 1'b0;
    cons_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // All features 0x95 -> level 9 in either build.
    send({NF{8'h95}}, 1'b1, 0);
    repeat (6) @(posedge clk);
    #1;

    // Feature 0 = 0x95, 1 = 0xF9 (saturates when rounding), 2 = 0x07.
    send({8'h07, 8'hF9, 8'h95}, 1'b1, 0);
    repeat (6) @(posedge clk);
    #1;

    // Three-beat sample then a fresh one-beat sample.
    send(FDW'($urandom()), 1'b0, 0);
    send(FDW'($urandom()), 1'b0, 0);
    send(FDW'($urandom()), 1'b1, 0);
    send(FDW'($urandom()), 1'b1, 0);
    repeat (6) @(posedge clk);
    #1;

    // Downstream busy for five PRESENT cycles.
    next_lat = 8;
    send(FDW'($urandom()), 1'b1, 0);
    cons_busy = 1'b1;
    repeat (7) @(posedge clk);
    #1 cons_busy = 1'b0;
    next_lat = 3;
    repeat (6) @(posedge clk);
    #1;

    // Reset while the beat sits in WAIT.
    send(FDW'($urandom()), 1'b0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send(FDW'($urandom()), 1'b1, 0);
    repeat (6) @(posedge clk);
    #1;

    // Back-to-back stream with feat_valid never dropping.
    stream_on = 1;
    have_prev = 0;
    for (int n = 0; n < 8; n++) send(FDW'($urandom()), 1'($urandom_range(0, 1)), 1);
    feat_valid = 1'b0;
    stream_on = 0;

    repeat (10) @(posedge clk);
    #1;
    chk("drain", 64'(oq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qtz_im_fetch_ctrl.md
QTZ_IM_FETCH_CTRL -- requirements
Module: qtz_im_fetch_ctrl

Interface
REQ-001 SHALL have parameter HV_DIM, default 1024, hypervector width in bits.
REQ-002 SHALL have parameter FEATURES_PER_CC, default 59, features per input beat.
REQ-003 SHALL have parameter FEAT_WIDTH, default 8, unsigned feature width.
REQ-004 SHALL have parameter LVL_W, default 4, level index width (2**LVL_W levels), LVL_W <= FEAT_WIDTH.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port feat_valid  in  1  input beat valid.
REQ-008 SHALL have port feat_ready  out  1  input beat accepted when valid&&ready.
REQ-009 SHALL have port feat_data  in  FEATURES_PER_CC x FEAT_WIDTH  feature values, index 0 first.
REQ-010 SHALL have port feat_last  in  1  beat closes current sample.
REQ-011 SHALL have port im_rd_en  out  1  item-memory read strobe.
REQ-012 SHALL have port im_rd_addr  out  FEATURES_PER_CC x LVL_W  level index per feature.
REQ-013 SHALL have port im_rd_data  in  FEATURES_PER_CC x HV_DIM  level HVs, valid exactly 1 cycle after im_rd_en.
REQ-014 SHALL have port cons_busy  in  1  downstream register cannot capture this cycle.
REQ-015 SHALL have port im_fetch_outputs  out  FEATURES_PER_CC x HV_DIM  registered level HVs.
REQ-016 SHALL have port qtz_out_reg_en  out  1  one-cycle capture strobe for downstream output register.
REQ-017 SHALL have port mapping_hv_segment  out  1  segment select accompanying qtz_out_reg_en.
REQ-018 SHALL have port sample_done  out  1  one-cycle pulse when last beat of a sample is delivered.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, WAIT, PRESENT.
REQ-020 SHALL assert feat_ready only in IDLE; on valid&&ready latch quantized levels and feat_last, go to FETCH.
REQ-021 SHALL in FETCH drive im_rd_en=1 for exactly one cycle with latched im_rd_addr, then go to WAIT.
REQ-022 SHALL in WAIT register im_rd_data into im_fetch_outputs, then go to PRESENT.
REQ-023 SHALL in PRESENT assert qtz_out_reg_en=1 when cons_busy=0, then return to IDLE; stay in PRESENT with outputs held while cons_busy=1.
REQ-024 SHALL hold im_fetch_outputs and mapping_hv_segment stable from WAIT exit until leaving PRESENT.
REQ-025 SHALL start each sample with segment 0 and toggle it after each delivered beat; on delivery of a feat_last beat, pulse sample_done with qtz_out_reg_en and reset segment to 0.
REQ-026 SHALL give minimum latency accept-to-qtz_out_reg_en of 3 cycles and peak throughput of one beat per 4 cycles.
REQ-027 SHALL keep im_rd_addr unchanged outside FETCH (holds last value).
REQ-028 SHALL ignore feat_valid outside IDLE; feat_data not sampled.
REQ-029 SHALL compute level (default) as truncation: feat >> (FEAT_WIDTH-LVL_W).

Reset
REQ-030 SHALL on rst=1 at a clock edge enter IDLE, regardless of state, discarding any in-flight beat.
REQ-031 SHALL reset feat_ready=0 during the rst cycle, im_rd_en=0, qtz_out_reg_en=0, sample_done=0, mapping_hv_segment=0, im_rd_addr=0, im_fetch_outputs=0.
REQ-032 SHALL assert feat_ready on the first cycle after rst deasserts.

Configuration
REQ-033 SHALL, with QTZ_ROUND_EN defined, compute level = min((feat + 2**(FEAT_WIDTH-LVL_W-1)) >> (FEAT_WIDTH-LVL_W), 2**LVL_W-1) using FEAT_WIDTH+1-bit arithmetic (no wrap); for LVL_W==FEAT_WIDTH level = feat.
REQ-034 SHALL, without QTZ_ROUND_EN, use truncation per REQ-029; all timing identical in both builds.

Verification
REQ-035 SHALL cover: reset, one beat all features=0x95, LVL_W=4, feat_last=1 -> im_rd_addr all 9 in FETCH, qtz_out_reg_en and sample_done at cycle+3, segment 0.
REQ-036 SHALL cover: QTZ_ROUND_EN, features 0x95/0xF9/0x07 -> addrs 9/15 (saturated)/0; without macro -> 9/15/0 for 0x95/0xF9/0x07 truncated.
REQ-037 SHALL cover: three beats, last on third -> mapping_hv_segment 0,1,0, sample_done only with third strobe; next sample starts at 0.
REQ-038 SHALL cover: cons_busy high 5 cycles in PRESENT -> qtz_out_reg_en delayed 5 cycles, outputs stable, feat_ready 0 throughout.
REQ-039 SHALL cover: rst asserted in WAIT -> no qtz_out_reg_en, outputs zeroed, feat_ready=1 one cycle after rst falls.
REQ-040 SHALL cover: feat_valid held high continuously -> acceptances exactly 4 cycles apart, each beat's im_rd_data delivered unaltered.
